byte_serial_wide_adder: RTL and testbench

- Upstream sequencer and downstream collector for the team's 8-bit CLA adder. It adds two operands wider than 8 bits by feeding one byte pair per cycle into an internal eight_bit_cla_adder instance, LSB byte first.
- Carry is chained between bytes through a register, and the byte sums are assembled into the wide result.
- Valid/ready handshake on input and output, so it slots between an operand source and a result consumer.

---
 rtl/byte_serial_wide_adder.sv | 220 ++++++++++++++++++++++
 tb/tb_byte_serial_wide_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_wide_adder.sv
// byte_serial_wide_adder: adds two NBYTES*8-bit operands one byte pair per
// cycle through a single 8-bit carry-lookahead adder, LSB byte first.
// The carry between bytes is kept in a register and the byte sums are
// assembled into a held wide result. Valid/ready handshakes on both sides.
//
// Optional build macro: OVERFLOW_DETECT_EN adds the 'ovf' output, which
// flags two's-complement signed overflow of the wide result.
//
// Also holds eight_bit_cla_adder, the combinational byte adder used here.

// eight_bit_cla_adder: purely combinational 8-bit adder with full carry
// lookahead (every carry is a flat sum-of-products of g/p and c_i).
module eight_bit_cla_adder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;
  logic       acc;
  logic       pp;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_i.
  always_comb begin
    acc      = 1'b0;
    pp       = 1'b0;
    carry    = '0;
    carry[0] = c_i;
    for (int i = 0; i < 8; i++) begin
      acc = gen[i];
      pp  = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & gen[j]);
        pp  = pp & prop[j];
      end
      carry[i+1] = acc | (pp & c_i);
    end
  end

  assign s_o = prop ^ carry[7:0];
  assign c_o = carry[8];

endmodule

// Byte-serial wide adder top. NBYTES must lie in 2..16.
module byte_serial_wide_adder #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
`ifdef OVERFLOW_DETECT_EN
  output logic                  ovf,
`endif
  output logic                  busy
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = $clog2(NBYTES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            out_valid_q, out_valid_d;

  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic [7:0]      add_s;
  logic            add_co;
  logic            accept;
  logic            take;
  logic            last_byte;

  // Byte lane selected by the running index feeds the shared adder.
  assign add_a = a_q[8*idx_q +: 8];
  assign add_b = b_q[8*idx_q +: 8];

  eight_bit_cla_adder u_cla (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_co)
  );

  assign accept    = (state_q == StIdle) && in_valid;
  assign take      = (state_q == StDone) && out_ready;
  assign last_byte = (state_q == StRun) && (idx_q == LastIdx);

  // Next-state logic for the sequencer and the result collector.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Operands are captured so later changes on a/b cannot leak in.
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[8*idx_q +: 8] = add_s;
        carry_d             = add_co;
        if (idx_q == LastIdx) begin
          cout_d      = add_co;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        // Result is held until the consumer takes it; in_valid is ignored.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d;

  // Signed overflow: like-signed operands whose result sign differs.
  // The final byte's adder output carries the result MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (accept || take) begin
      ovf_d = 1'b0;
    end else if (last_byte) begin
      ovf_d = (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_byte_serial_wide_adder.sv
// Directed self-checking bench for byte_serial_wide_adder (NBYTES=4).
// Build with OVERFLOW_DETECT_EN defined to also check the ovf output.
module tb_byte_serial_wide_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;
`ifdef OVERFLOW_DETECT_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byte_serial_wide_adder #(
    .NBYTES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef OVERFLOW_DETECT_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  // Presents one operand set, scrambles a/b/cin after the accepting edge,
  // and counts edges until out_valid (bounded at 20).
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                         output int lat);
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 32'h1234; b = 32'h5678; cin = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    n_cmp++; if (sum !== 32'h0) begin n_err++; $display("FAIL rst_sum: got %h exp 00000000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b exp 0", cout); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_wins_busy: got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    int lat;
    run_txn(32'h000000FF, 32'h00000001, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d exp 4", lat); end
    n_cmp++; if (sum !== 32'h00000100) begin n_err++; $display("FAIL basic_sum: got %h exp 00000100", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %b exp 0", cout); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready: got %b exp 0", in_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b exp 1", busy); end
    drain();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ret_ready: got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_ret_valid: got %b exp 0", out_valid); end
  endtask

  task automatic test_ripple();
    int lat;
    run_txn(32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ripple_latency: got %0d exp 4", lat); end
    n_cmp++; if (sum !== 32'h00000000) begin n_err++; $display("FAIL ripple_sum: got %h exp 00000000", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL ripple_cout: got %b exp 1", cout); end
    drain();
  endtask

  task automatic test_signed_edge();
    int lat;
    run_txn(32'h80000000, 32'h80000000, 1'b0, lat);
    n_cmp++; if (sum !== 32'h00000000) begin n_err++; $display("FAIL neg_sum: got %h exp 00000000", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL neg_cout: got %b exp 1", cout); end
`ifdef OVERFLOW_DETECT_EN
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL neg_ovf: got %b exp 1", ovf); end
`endif
    drain();
    run_txn(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
    n_cmp++; if (sum !== 32'h80000000) begin n_err++; $display("FAIL pos_sum: got %h exp 80000000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL pos_cout: got %b exp 0", cout); end
`ifdef OVERFLOW_DETECT_EN
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL pos_ovf: got %b exp 1", ovf); end
`endif
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad_valid = 0;
    int bad_sum   = 0;
    int bad_cout  = 0;
    int bad_ready = 0;
    run_txn(32'h12345678, 32'h11111111, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL bp_latency: got %0d exp 4", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      a = 32'h00000001; b = 32'h00000001; cin = 1'b0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1) bad_valid++;
      if (sum !== 32'h23456789) bad_sum++;
      if (cout !== 1'b0) bad_cout++;
      if (in_ready !== 1'b0) bad_ready++;
    end
    in_valid = 1'b0;
    n_cmp++; if (bad_valid !== 0) begin n_err++; $display("FAIL bp_valid_hold: got %0d drops exp 0", bad_valid); end
    n_cmp++; if (bad_sum !== 0) begin n_err++; $display("FAIL bp_sum_hold: got %0d changes exp 0 (sum %h)", bad_sum, sum); end
    n_cmp++; if (bad_cout !== 0) begin n_err++; $display("FAIL bp_cout_hold: got %0d changes exp 0", bad_cout); end
    n_cmp++; if (bad_ready !== 0) begin n_err++; $display("FAIL bp_in_ready: got %0d highs exp 0", bad_ready); end
    drain();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ret_ready: got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_ret_valid: got %b exp 0", out_valid); end
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_not_queued: got busy %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen_valid = 0;
    @(posedge clk); #1;
    a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b exp 0", out_valid); end
    n_cmp++; if (sum !== 32'h0) begin n_err++; $display("FAIL mid_sum: got %h exp 00000000", sum); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b exp 0", busy); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen_valid++;
    end
    n_cmp++; if (seen_valid !== 0) begin n_err++; $display("FAIL mid_no_partial: got %0d valids exp 0", seen_valid); end
    run_txn(32'h00000010, 32'h00000020, 1'b0, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL mid_after_latency: got %0d exp 4", lat); end
    n_cmp++; if (sum !== 32'h00000030) begin n_err++; $display("FAIL mid_after_sum: got %h exp 00000030", sum); end
    drain();
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    a = 32'h01010101; b = 32'h02020202; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 32'hFF00FF00; b = 32'h01000100;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_first_accept: got busy %b exp 1", busy); end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid1: got %b exp 1", out_valid); end
        n_cmp++; if (sum !== 32'h03030303) begin n_err++; $display("FAIL b2b_sum1: got %h exp 03030303", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL b2b_cout1: got %b exp 0", cout); end
      end
      if (k == 5) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_gap: got in_ready %b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b exp 0", out_valid); end
      end
      if (k == 6) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got busy %b exp 1", busy); end
        in_valid = 1'b0;
      end
      if (k == 10) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2: got %b exp 1", out_valid); end
        n_cmp++; if (sum !== 32'h00010000) begin n_err++; $display("FAIL b2b_sum2: got %h exp 00010000", sum); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL b2b_cout2: got %b exp 1", cout); end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end_ready: got %b exp 1", in_ready); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_signed_edge();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
